// File: rtl/multi_state_seq.sv
// Multicycle step sequencer for the MIPS multicycle controller: owns the step
// register, handles memory stalls, retire/halt/overrun and the debug counters.
module multi_state_seq #(
  parameter int MAX_STATE = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             next_ins,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  output logic [2:0]       state,
  output logic             retire,
  output logic             halted,
  output logic             seq_err,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] stall_count
);

  // Step encoding seen by the controller: 0 FETCH, 1 DECODE, 2 EXEC/ADDR,
  // 3 MEM/ALUWB, 4 MEMWB.
  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_LAST  = 3'(MAX_STATE);
  localparam logic [2:0] S_STEP  = 3'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Valid/ready: a memory step completes only on a cycle where mem_req and
  // mem_ready are both high; mem_req with mem_ready low holds the step.
  logic active;
  logic stall;
  logic overrun;

  assign active  = en & ~halted;
  assign stall   = mem_req & ~mem_ready;
  // ">=" also catches unreachable codes above the last legal step.
  assign overrun = (state >= S_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      retire      <= 1'b0;
      halted      <= 1'b0;
      seq_err     <= 1'b0;
      instr_count <= '0;
      cycle_count <= '0;
      stall_count <= '0;
    end else begin
      retire <= 1'b0;
      if (active) begin
        cycle_count <= cycle_count + CNT_ONE;
        if (stall) begin
          stall_count <= stall_count + CNT_ONE;
        end else if (next_ins) begin
          state       <= S_FETCH;
          instr_count <= instr_count + CNT_ONE;
          retire      <= 1'b1;
          if (halt_req) begin
            halted <= 1'b1;
          end
        end else if (overrun) begin
          state   <= S_FETCH;
          seq_err <= 1'b1;
        end else begin
          state <= state + S_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_state_seq.sv
// Directed bench for multi_state_seq: a behavioural model checked every cycle
// plus hand-computed milestones; a CNT_W=4 instance shares stimulus for wrap.
module tb_multi_state_seq;

  logic clk;
  logic rst_n;
  logic en;
  logic next_ins;
  logic mem_req;
  logic mem_ready;
  logic halt_req;

  logic [2:0]  state_a, state_b;
  logic        retire_a, retire_b, halted_a, halted_b, seq_err_a, seq_err_b;
  logic [31:0] instr_a, cycle_a, stall_a;
  logic [3:0]  instr_b, cycle_b, stall_b;

  int tests = 0;
  int fails = 0;

  // Model: counts kept as unbounded ints, truncated only when compared.
  int m_state = 0;
  int m_instr = 0;
  int m_cycle = 0;
  int m_stall = 0;
  bit m_retire = 0;
  bit m_halted = 0;
  bit m_err = 0;

  multi_state_seq #(.MAX_STATE(4), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .next_ins(next_ins), .mem_req(mem_req),
    .mem_ready(mem_ready), .halt_req(halt_req), .state(state_a), .retire(retire_a),
    .halted(halted_a), .seq_err(seq_err_a), .instr_count(instr_a),
    .cycle_count(cycle_a), .stall_count(stall_a)
  );

  multi_state_seq #(.MAX_STATE(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .next_ins(next_ins), .mem_req(mem_req),
    .mem_ready(mem_ready), .halt_req(halt_req), .state(state_b), .retire(retire_b),
    .halted(halted_b), .seq_err(seq_err_b), .instr_count(instr_b),
    .cycle_count(cycle_b), .stall_count(stall_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_instr = 0; m_cycle = 0; m_stall = 0;
    m_retire = 0; m_halted = 0; m_err = 0;
  endtask

  // One edge of the sequencer described by its rules: stall beats retire,
  // retire beats overrun, otherwise advance one step.
  always @(posedge clk) begin
    if (rst_n) begin
      m_retire = 0;
      if (en && !m_halted) begin
        m_cycle++;
        if (mem_req && !mem_ready) m_stall++;
        else if (next_ins) begin
          m_state = 0;
          m_instr++;
          m_retire = 1;
          if (halt_req) m_halted = 1;
        end else if (m_state >= 4) begin
          m_state = 0;
          m_err = 1;
        end else m_state++;
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    chk("state", 32'(state_a), 32'(m_state));
    chk("retire", 32'(retire_a), 32'(m_retire));
    chk("halted", 32'(halted_a), 32'(m_halted));
    chk("seq_err", 32'(seq_err_a), 32'(m_err));
    chk("instr_count", instr_a, 32'(m_instr));
    chk("cycle_count", cycle_a, 32'(m_cycle));
    chk("stall_count", stall_a, 32'(m_stall));
    chk("state_w4", 32'(state_b), 32'(m_state));
    chk("instr_count_w4", 32'(instr_b), 32'(m_instr % 16));
    chk("cycle_count_w4", 32'(cycle_b), 32'(m_cycle % 16));
    chk("stall_count_w4", 32'(stall_b), 32'(m_stall % 16));
  end

  // driver: apply inputs for one edge, return 2 time units after it
  task automatic cyc(input bit e, input bit ni, input bit mq, input bit mr, input bit hr);
    en = e; next_ins = ni; mem_req = mq; mem_ready = mr; halt_req = hr;
    @(posedge clk);
    #2;
  endtask

  task automatic pin(input string name, input int st, input int ins, input int cy, input int sl);
    chk({name, "_state"}, 32'(state_a), 32'(st));
    chk({name, "_instr"}, instr_a, 32'(ins));
    chk({name, "_cycle"}, cycle_a, 32'(cy));
    chk({name, "_stall"}, stall_a, 32'(sl));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; next_ins = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;
    halt_req = 1'b0;
    #3;
    chk("reset_state", 32'(state_a), 32'd0);
    chk("reset_flags", {29'd0, retire_a, halted_a, seq_err_a}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // R-type retiring at step 3
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0);
    chk("rtype_s2", 32'(state_a), 32'd2);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 0);
    pin("rtype", 0, 1, 4, 0);
    chk("rtype_retire", 32'(retire_a), 32'd1);

    // load: memory at steps 0 and 3, two wait cycles in step 3
    cyc(1, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("load_hold", 32'(state_a), 32'd3);
    cyc(1, 0, 1, 1, 0);
    chk("load_s4", 32'(state_a), 32'd4);
    cyc(1, 1, 0, 1, 0);
    pin("load", 0, 2, 11, 2);

    // next_ins while the memory is still busy
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 1, 0, 0);
    pin("busy_hold", 3, 2, 15, 3);
    chk("busy_noretire", 32'(retire_a), 32'd0);
    cyc(1, 1, 1, 1, 0);
    pin("busy_done", 0, 3, 16, 3);

    // overrun: never end the instruction
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 1, 0);
    pin("overrun", 0, 3, 21, 3);
    chk("overrun_err", 32'(seq_err_a), 32'd1);

    // en low in the middle of a stall, then resume
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, i[0], 0);
    pin("en_low", 2, 3, 24, 4);
    cyc(1, 1, 0, 1, 0);
    pin("resume", 0, 4, 25, 4);

    // twelve single-cycle retires bring the count to 16
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 1, 0);
    chk("wrap_w32", instr_a, 32'd16);
    chk("wrap_w4", 32'(instr_b), 32'd0);
    chk("wrap_cycle_w4", 32'(cycle_b), 32'd5);

    // reset asserted between edges
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    pin("async_rst", 0, 0, 0, 0);
    chk("async_rst_flags", {29'd0, retire_a, halted_a, seq_err_a}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // halt retiring at step 2, then frozen despite stimulus
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 0, 1, 1);
    pin("halt", 0, 1, 3, 0);
    chk("halt_flag", 32'(halted_a), 32'd1);
    for (int i = 0; i < 10; i++) cyc(1, i[0], i[1], i[2], 1);
    pin("halt_frozen", 0, 1, 3, 0);
    chk("halt_retire_low", 32'(retire_a), 32'd0);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
